// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory over req/ack
// and hands instructions to the processor over valid/ready.
// Optional build macro FETCH_PERF_COUNT_EN adds saturating fetch/flush counters.
module fetch_unit #(
    parameter int                  PC_WIDTH    = 8,
    parameter int                  INSTR_WIDTH = 32,
    parameter int                  PC_STEP     = 1,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall,
    input  logic                   branch_taken,
    input  logic [PC_WIDTH-1:0]    branch_target,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic [PC_WIDTH-1:0]    pc_counter
`ifdef FETCH_PERF_COUNT_EN
    ,
    output logic [15:0]            perf_fetch_count,
    output logic [15:0]            perf_flush_count
`endif
);

    // state | meaning
    // IDLE  | no request outstanding, waiting for stall to drop
    // REQ   | read outstanding at fetch_pc, result will be delivered
    // HOLD  | instruction presented, waiting for instr_ready
    // DROP  | read outstanding at a stale address, result will be discarded
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } state_t;

    localparam logic [PC_WIDTH-1:0] PC_INC = PC_WIDTH'(PC_STEP);

    state_t              state;
    logic [PC_WIDTH-1:0] fetch_pc;
    logic [PC_WIDTH-1:0] pc_next;

    assign pc_next = fetch_pc + PC_INC;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            instr_valid <= 1'b0;
            instr_out   <= '0;
            pc_counter  <= '0;
        end else if (branch_taken) begin
            // Redirect wins over everything; an unanswered read must still
            // complete, so it is parked in DROP with its old address.
            fetch_pc    <= branch_target;
            instr_valid <= 1'b0;
            if (state == DROP) begin
                state <= DROP;
            end else if (state == REQ && !imem_ack) begin
                state <= DROP;
            end else if (!stall) begin
                state     <= REQ;
                imem_req  <= 1'b1;
                imem_addr <= branch_target;
            end else begin
                state    <= IDLE;
                imem_req <= 1'b0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (!stall) begin
                        state     <= REQ;
                        imem_req  <= 1'b1;
                        imem_addr <= fetch_pc;
                    end
                end
                REQ: begin
                    if (imem_ack) begin
                        state       <= HOLD;
                        imem_req    <= 1'b0;
                        instr_out   <= imem_rdata;
                        pc_counter  <= fetch_pc;
                        instr_valid <= 1'b1;
                        fetch_pc    <= pc_next;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        if (!stall) begin
                            state     <= REQ;
                            imem_req  <= 1'b1;
                            imem_addr <= fetch_pc;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DROP: begin
                    if (imem_ack) begin
                        if (!stall) begin
                            state     <= REQ;
                            imem_addr <= fetch_pc;
                        end else begin
                            state    <= IDLE;
                            imem_req <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_COUNT_EN
    // A handshake coinciding with a redirect is flushed, so it is not a fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_count <= '0;
            perf_flush_count <= '0;
        end else begin
            if (instr_valid && instr_ready && !branch_taken && perf_fetch_count != 16'hFFFF) begin
                perf_fetch_count <= perf_fetch_count + 16'd1;
            end
            if (branch_taken && perf_flush_count != 16'hFFFF) begin
                perf_flush_count <= perf_flush_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by a random
// phase, all checked against a PC-sequence reference model.
module tb_fetch_unit;
    localparam int PW = 8;
    localparam int IW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          stall = 1'b0;
    logic          branch_taken = 1'b0;
    logic [PW-1:0] branch_target = '0;
    logic          imem_req;
    logic [PW-1:0] imem_addr;
    logic          imem_ack = 1'b0;
    logic [IW-1:0] imem_rdata = '0;
    logic          instr_valid;
    logic          instr_ready = 1'b1;
    logic [IW-1:0] instr_out;
    logic [PW-1:0] pc_counter;

    logic          b_stall = 1'b0;
    logic          b_branch = 1'b0;
    logic [PW-1:0] b_target = '0;
    logic          b_req;
    logic [PW-1:0] b_addr;
    logic          b_ack = 1'b0;
    logic [IW-1:0] b_rdata = '0;
    logic          b_valid;
    logic          b_ready = 1'b1;
    logic [IW-1:0] b_instr;
    logic [PW-1:0] b_pc;

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_out(instr_out), .pc_counter(pc_counter)
    );

    fetch_unit #(.RESET_PC(8'hFE)) dut_fe (
        .clk(clk), .rst_n(rst_n), .stall(b_stall),
        .branch_taken(b_branch), .branch_target(b_target),
        .imem_req(b_req), .imem_addr(b_addr),
        .imem_ack(b_ack), .imem_rdata(b_rdata),
        .instr_valid(b_valid), .instr_ready(b_ready),
        .instr_out(b_instr), .pc_counter(b_pc)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            failures = 0;
    logic [IW-1:0] mem [256];
    int            mem_lat = 0;
    int            mem_wait = 0;
    bit            rand_lat = 1'b0;
    logic [PW-1:0] exp_pc = '0;
    logic [PW-1:0] deliv_q[$];
    logic [PW-1:0] b_q[$];
    int            deliveries = 0;

    bit            prev_ok = 1'b0;
    logic          p_req, p_ack, p_valid, p_ready, p_branch, p_stall;
    logic [PW-1:0] p_addr, p_pc;
    logic [IW-1:0] p_rdata, p_instr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Reference model evaluated on the values about to be clocked in.
    task automatic model_update();
        if (!rst_n) begin
            prev_ok = 1'b0;
            return;
        end
        chk("req_valid_exclusive", 32'(imem_req & instr_valid), 32'd0);
        if (prev_ok) begin
            if (p_req && !p_ack) begin
                chk("req_held", 32'(imem_req), 32'd1);
                chk("addr_stable", 32'(imem_addr), 32'(p_addr));
            end
            if (!p_req && imem_req) chk("launch_unstalled", 32'(p_stall), 32'd0);
            if (imem_req && (!p_req || p_ack) && !(p_req && p_branch))
                chk("launch_addr", 32'(imem_addr), 32'(exp_pc));
            if (p_valid && !p_ready && !p_branch) begin
                chk("hold_valid", 32'(instr_valid), 32'd1);
                chk("hold_pc", 32'(pc_counter), 32'(p_pc));
                chk("hold_instr", instr_out, p_instr);
            end
            if (!p_valid && instr_valid) begin
                chk("valid_after_ack", 32'(p_req & p_ack & ~p_branch), 32'd1);
                chk("valid_pc", 32'(pc_counter), 32'(p_addr));
                chk("valid_data", instr_out, p_rdata);
            end
            if (p_branch) chk("flush_on_branch", 32'(instr_valid), 32'd0);
        end
        if (branch_taken) begin
            exp_pc = branch_target;
        end else if (instr_valid && instr_ready) begin
            chk("deliver_pc", 32'(pc_counter), 32'(exp_pc));
            chk("deliver_data", instr_out, mem[exp_pc]);
            deliv_q.push_back(pc_counter);
            deliveries++;
            exp_pc = exp_pc + 8'd1;
        end
        prev_ok  = 1'b1;
        p_req    = imem_req;
        p_ack    = imem_ack;
        p_addr   = imem_addr;
        p_rdata  = imem_rdata;
        p_valid  = instr_valid;
        p_ready  = instr_ready;
        p_branch = branch_taken;
        p_stall  = stall;
        p_pc     = pc_counter;
        p_instr  = instr_out;
    endtask

    task automatic mem_respond();
        if (!imem_req || !rst_n) begin
            imem_ack = 1'b0;
            mem_wait = 0;
        end else begin
            if (imem_ack) mem_wait = 0;
            if (mem_wait == 0 && rand_lat) mem_lat = $urandom_range(0, 3);
            if (mem_wait >= mem_lat) begin
                imem_ack   = 1'b1;
                imem_rdata = mem[imem_addr];
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = $urandom;
            end
            mem_wait++;
        end
    endtask

    task automatic tick();
        model_update();
        if (rst_n && b_valid && b_ready && b_q.size() < 3) begin
            b_q.push_back(b_pc);
            chk("fe_data", b_instr, mem[b_pc]);
        end
        @(posedge clk);
        #1;
        mem_respond();
        b_ack   = b_req;
        b_rdata = mem[b_addr];
    endtask

    function automatic bit cond(input int which);
        case (which)
            0: return imem_req;
            1: return instr_valid;
            2: return imem_ack;
            3: return !imem_req;
            default: return imem_req && imem_addr == 8'h05;
        endcase
    endfunction

    task automatic wait_for(input int which, input string tag);
        int n = 0;
        while (!cond(which) && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 32'(n < 200), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        branch_taken = 1'b0;
        stall = 1'b0;
        imem_ack = 1'b0;
        mem_wait = 0;
        repeat (2) tick();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr_out, 32'd0);
        chk("rst_pc", 32'(pc_counter), 32'd0);
        chk("rst_fe_addr", 32'(b_addr), 32'hFE);
        exp_pc = 8'h00;
        deliv_q.delete();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0]    vhist;
        logic [PW-1:0] cap_pc;
        logic [IW-1:0] cap_instr;
        int            n;
        int            start_deliv;

        for (int i = 0; i < 256; i++) mem[i] = $urandom;

        // Zero-wait memory, ready always high.
        do_reset();
        vhist = '0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i < 8) vhist[i] = instr_valid;
        end
        chk("zw_valid_pattern", 32'(vhist), 32'h0000_00AA);
        chk("zw_count", 32'(deliv_q.size() >= 4), 32'd1);
        for (int i = 0; i < 4; i++) chk("zw_pc_seq", 32'(deliv_q[i]), 32'(i));
        chk("fe_count", 32'(b_q.size()), 32'd3);
        chk("fe_pc0", 32'(b_q[0]), 32'hFE);
        chk("fe_pc1", 32'(b_q[1]), 32'hFF);
        chk("fe_pc2", 32'(b_q[2]), 32'h00);

        // Memory answers after three wait cycles.
        wait_for(3, "wait_req_low");
        mem_lat = 3;
        wait_for(0, "wait_req_slow");
        cap_pc = imem_addr;
        n = 0;
        while (!imem_ack && n < 10) begin
            chk("slow_req", 32'(imem_req), 32'd1);
            chk("slow_addr", 32'(imem_addr), 32'(cap_pc));
            tick();
            n++;
        end
        chk("slow_wait_cycles", 32'(n), 32'd3);
        tick();
        chk("slow_valid", 32'(instr_valid), 32'd1);
        chk("slow_pc", 32'(pc_counter), 32'(cap_pc));
        chk("slow_data", instr_out, mem[cap_pc]);
        tick();
        chk("slow_single_pulse", 32'(instr_valid), 32'd0);

        // Back-pressure from the processor.
        mem_lat = 0;
        instr_ready = 1'b0;
        wait_for(1, "wait_valid_bp");
        cap_pc = pc_counter;
        cap_instr = instr_out;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", 32'(instr_valid), 32'd1);
            chk("bp_pc", 32'(pc_counter), 32'(cap_pc));
            chk("bp_instr", instr_out, cap_instr);
            chk("bp_no_req", 32'(imem_req), 32'd0);
        end
        instr_ready = 1'b1;
        tick();
        chk("bp_release_valid", 32'(instr_valid), 32'd0);
        chk("bp_release_req", 32'(imem_req), 32'd1);

        // Stall while holding, accept under stall, then resume.
        instr_ready = 1'b0;
        wait_for(1, "wait_valid_stall");
        stall = 1'b1;
        repeat (2) tick();
        chk("stall_hold_valid", 32'(instr_valid), 32'd1);
        instr_ready = 1'b1;
        tick();
        chk("stall_accept_valid", 32'(instr_valid), 32'd0);
        chk("stall_accept_req", 32'(imem_req), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_idle_req", 32'(imem_req), 32'd0);
        end
        stall = 1'b0;
        tick();
        chk("stall_resume_req", 32'(imem_req), 32'd1);

        // Reset while an instruction is held.
        instr_ready = 1'b0;
        wait_for(1, "wait_valid_rst");
        rst_n = 1'b0;
        #1;
        chk("rst_hold_valid", 32'(instr_valid), 32'd0);
        chk("rst_hold_pc", 32'(pc_counter), 32'd0);
        instr_ready = 1'b1;
        do_reset();

        // Redirect while a read at 0x05 is outstanding.
        mem_lat = 4;
        wait_for(4, "wait_addr5");
        chk("br_pre_ack", 32'(imem_ack), 32'd0);
        branch_taken = 1'b1;
        branch_target = 8'h40;
        tick();
        branch_taken = 1'b0;
        chk("drop_req", 32'(imem_req), 32'd1);
        chk("drop_addr", 32'(imem_addr), 32'h05);
        chk("drop_valid", 32'(instr_valid), 32'd0);
        wait_for(2, "wait_drop_ack");
        tick();
        chk("drop_discard_valid", 32'(instr_valid), 32'd0);
        chk("redirect_req", 32'(imem_req), 32'd1);
        chk("redirect_addr", 32'(imem_addr), 32'h40);
        wait_for(1, "wait_redirect_valid");
        chk("redirect_pc", 32'(pc_counter), 32'h40);
        chk("redirect_data", instr_out, mem[8'h40]);

        // Reset while a read is outstanding.
        mem_lat = 6;
        tick();
        wait_for(0, "wait_req_rst");
        tick();
        chk("pre_rst_req", 32'(imem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_req", 32'(imem_req), 32'd0);
        chk("rst_mid_valid", 32'(instr_valid), 32'd0);
        do_reset();

        // Random traffic against the reference model.
        rand_lat = 1'b1;
        start_deliv = deliveries;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                do_reset();
            end
            stall         = ($urandom_range(0, 3) == 0);
            branch_taken  = ($urandom_range(0, 19) == 0);
            branch_target = PW'($urandom);
            instr_ready   = ($urandom_range(0, 2) != 0);
            tick();
        end
        branch_taken = 1'b0;
        stall = 1'b0;
        tick();
        chk("rand_progress", 32'((deliveries - start_deliv) > 150), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of Processor.
- Owns the program counter and issues word reads to instruction memory over a req/ack handshake.
- Presents each fetched instruction with its pc_counter to Processor over a valid/ready handshake.
- Accepts branch redirects from execute and stall requests from the pipeline.

Parameters:
- PC_WIDTH, 8, width of program counter and instruction memory address.
- INSTR_WIDTH, 32, instruction word width.
- PC_STEP, 1, PC increment per sequential fetch (word addressing).
- RESET_PC, 0, first fetch address after reset.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  while high, no new memory request is launched.
- branch_taken  input  1  single-cycle redirect pulse from execute.
- branch_target  input  PC_WIDTH  redirect address; sampled when branch_taken=1.
- imem_req  output  1  memory read request.
- imem_addr  output  PC_WIDTH  read address; stable while imem_req=1.
- imem_ack  input  1  memory response strobe; imem_rdata is valid in the same cycle.
- imem_rdata  input  INSTR_WIDTH  read data.
- instr_valid  output  1  instr_out and pc_counter are valid.
- instr_ready  input  1  Processor accepts the instruction.
- instr_out  output  INSTR_WIDTH  fetched instruction.
- pc_counter  output  PC_WIDTH  address of instr_out.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE; fetch_pc=RESET_PC.
  - imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr_out=0, pc_counter=0.
  - Asserting rst_n low mid-request drops the request and any held instruction immediately.
- States: IDLE, REQ, HOLD, DROP.
- IDLE: if stall=0, go to REQ next cycle; otherwise stay in IDLE.
- REQ:
  - imem_req=1, imem_addr=fetch_pc.
  - Wait for imem_ack; the request is never withdrawn before ack.
  - On ack: instr_out<=imem_rdata, pc_counter<=fetch_pc, instr_valid<=1, fetch_pc<=fetch_pc+PC_STEP, go to HOLD.
- HOLD:
  - instr_valid=1; instr_out and pc_counter are held stable until instr_ready=1.
  - On instr_ready=1: instr_valid<=0. Go to REQ if stall=0, else to IDLE.
- DROP:
  - imem_req stays 1 at the old address until imem_ack.
  - The returned data is discarded (instr_valid stays 0).
  - Then go to REQ if stall=0, else to IDLE.
- Best-case throughput: one instruction per 2 cycles (zero-wait memory, ready held high).
- Arithmetic: fetch_pc+PC_STEP is computed mod 2^PC_WIDTH; 8'hFF+1 wraps to 8'h00 with no flag.
- branch_taken has the highest priority over ack, ready and stall:
  - Always: fetch_pc<=branch_target, instr_valid<=0 (flush).
  - In IDLE or HOLD: go to REQ if stall=0, else to IDLE.
  - In REQ without ack in the same cycle: go to DROP.
  - In REQ with ack in the same cycle: discard imem_rdata and go to REQ (if stall=0) or IDLE.
  - In DROP: update the target only; remain in DROP.
- Stall:
  - Never aborts an outstanding request; it blocks only the launch of a new one.
  - A held instruction may still be accepted while stall=1.
- Simultaneous instr_ready and branch_taken in HOLD: the held instruction counts as not consumed (flushed).

Optional Feature:
- Macro FETCH_PERF_COUNT_EN.
- When defined, adds two outputs:
  - perf_fetch_count [15:0]: increments on each instr_valid&&instr_ready handshake.
  - perf_flush_count [15:0]: increments on each branch_taken.
  - Both saturate at 16'hFFFF and reset to 0.
- When undefined, neither port nor counter logic exists; all other behaviour is identical.

Test Plan:
- Reset release, zero-wait memory (ack the cycle after req), instr_ready=1 -> pc_counter sequence 0,1,2,3 with instr_out=mem[pc]; instr_valid high every second cycle.
- Memory ack delayed 3 cycles -> imem_req and imem_addr held stable 3 cycles; a single instr_valid pulse with the correct pc_counter.
- instr_ready=0 for 5 cycles in HOLD -> instr_out and pc_counter unchanged; no new imem_req until ready is asserted.
- branch_taken with branch_target=8'h40 while REQ is outstanding at 8'h05 -> DROP, ack data discarded, next request at 8'h40, first valid pc_counter=8'h40.
- Start at RESET_PC=8'hFE -> pc_counter 8'hFE, 8'hFF, 8'h00.
- stall=1 during HOLD, then accept -> state IDLE, no imem_req until stall=0; rst_n pulled low mid-REQ -> imem_req and instr_valid go to 0 immediately.
